// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the instruction/data RAM port arbiter.
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} arb_state_e;
   typedef enum logic [1:0] {OWN_NONE, OWN_INSTR, OWN_DATA} arb_owner_e;
   localparam int unsigned BE_MAX_W = 128;
   localparam logic [BE_MAX_W-1:0] BE_ALL = '1;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/gnt/rvalid RAM port between fetch and load/store,
// data first, with a starvation bound that forces an instruction grant.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                instr_req_i,
   input  logic [ADDR_W-1:0]   instr_addr_i,
   output logic                instr_gnt_o,
   output logic                instr_rvalid_o,
   output logic [DATA_W-1:0]   instr_rdata_o,
   output logic                instr_err_o,
   input  logic                data_req_i,
   input  logic [ADDR_W-1:0]   data_addr_i,
   input  logic                data_we_i,
   input  logic [DATA_W/8-1:0] data_be_i,
   input  logic [DATA_W-1:0]   data_wdata_i,
   output logic                data_gnt_o,
   output logic                data_rvalid_o,
   output logic [DATA_W-1:0]   data_rdata_o,
   output logic                data_err_o,
   output logic                mem_req_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic                mem_we_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   input  logic                mem_gnt_i,
   input  logic                mem_rvalid_i,
   input  logic [DATA_W-1:0]   mem_rdata_i,
   input  logic                mem_err_i
);
   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   arb_state_e       state_q, state_d;
   arb_owner_e       owner_q, owner_d, sel;
   logic [CNT_W-1:0] starve_q, starve_d;
   logic             win_instr, sel_i, sel_d, gnt, rsp;

   // sel is the side currently presenting on the RAM port; it is locked to the owner once in WAIT_GNT
   always_comb begin
      win_instr      = instr_req_i & (~data_req_i | (starve_q == LIMIT));
      sel            = state_q == WAIT_GNT ? owner_q
                     : (state_q == IDLE && (instr_req_i || data_req_i)) ? (win_instr ? OWN_INSTR : OWN_DATA)
                     : OWN_NONE;
      sel_i          = rst_ni && sel == OWN_INSTR;
      sel_d          = rst_ni && sel == OWN_DATA;
      gnt            = (sel_i | sel_d) & mem_gnt_i;
      rsp            = rst_ni && state_q == WAIT_RVALID && mem_rvalid_i;
      state_d        = rsp ? IDLE : gnt ? WAIT_RVALID : (sel_i | sel_d) ? WAIT_GNT : state_q;
      owner_d        = rsp ? OWN_NONE : (sel_i | sel_d) ? sel : owner_q;
      starve_d       = !gnt ? starve_q
                     : (sel_d && instr_req_i) ? (starve_q == LIMIT ? LIMIT : starve_q + 1'b1)
                     : '0;
      mem_req_o      = sel_i | sel_d;
      mem_addr_o     = sel_i ? instr_addr_i : sel_d ? data_addr_i : '0;
      mem_we_o       = sel_d & data_we_i;
      mem_be_o       = sel_i ? BE_ALL[BE_W-1:0] : sel_d ? data_be_i : '0;
      mem_wdata_o    = sel_d ? data_wdata_i : '0;
      instr_gnt_o    = sel_i & mem_gnt_i;
      data_gnt_o     = sel_d & mem_gnt_i;
      instr_rvalid_o = rsp && owner_q == OWN_INSTR;
      data_rvalid_o  = rsp && owner_q == OWN_DATA;
      instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
      data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
      instr_err_o    = instr_rvalid_o & mem_err_i;
      data_err_o     = data_rvalid_o & mem_err_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         owner_q  <= OWN_NONE;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level model of the arbiter.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;
   localparam int LIMIT = 4;

   logic        clk = 0, rst_n = 0;
   logic        ireq = 0, dreq = 0, dwe = 0, g = 0, rv = 0, me = 0;
   logic [31:0] iaddr = 0, daddr = 0, dwd = 0, rd = 0;
   logic [3:0]  dbe = 0;
   logic        instr_gnt, instr_rvalid, instr_err, data_gnt, data_rvalid, data_err, mem_req, mem_we;
   logic [31:0] instr_rdata, data_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   int          checks = 0, errors = 0;
   int          m_own = 0, m_st = 0;
   bit          m_gr = 0, m_ig = 0, m_dg = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .instr_req_i(ireq), .instr_addr_i(iaddr), .instr_gnt_o(instr_gnt),
      .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
      .data_req_i(dreq), .data_addr_i(daddr), .data_we_i(dwe), .data_be_i(dbe),
      .data_wdata_i(dwd), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
      .data_rdata_o(data_rdata), .data_err_o(data_err),
      .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
      .mem_wdata_o(mem_wdata), .mem_gnt_i(g), .mem_rvalid_i(rv), .mem_rdata_i(rd), .mem_err_i(me)
   );

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask

   // Model: one outstanding transaction with an owner (0 none, 1 instr, 2 data) that is granted or not.
   task automatic model_step();
      int ro;
      bit erv;
      if (!rst_n) begin
         chk("rst_mem_req", mem_req, 0);
         chk("rst_igrant", instr_gnt, 0);
         chk("rst_dgrant", data_gnt, 0);
         chk("rst_irvalid", instr_rvalid, 0);
         chk("rst_drvalid", data_rvalid, 0);
         m_own = 0; m_gr = 0; m_st = 0; m_ig = 0; m_dg = 0;
      end else begin
         ro = m_own != 0 ? (m_gr ? 0 : m_own)
            : (ireq || dreq) ? ((dreq && !(ireq && m_st == LIMIT)) ? 2 : 1) : 0;
         chk("mem_req", mem_req, ro != 0);
         if (ro == 1) begin
            chk("i_addr", mem_addr, iaddr); chk("i_we", mem_we, 0);
            chk("i_be", mem_be, 4'hF);      chk("i_wdata", mem_wdata, 0);
         end
         if (ro == 2) begin
            chk("d_addr", mem_addr, daddr); chk("d_we", mem_we, dwe);
            chk("d_be", mem_be, dbe);       chk("d_wdata", mem_wdata, dwd);
         end
         m_ig = ro == 1 && g;
         m_dg = ro == 2 && g;
         chk("instr_gnt", instr_gnt, m_ig);
         chk("data_gnt", data_gnt, m_dg);
         erv = m_gr && rv;
         chk("instr_rvalid", instr_rvalid, erv && m_own == 1);
         chk("data_rvalid", data_rvalid, erv && m_own == 2);
         if (erv && m_own == 1) begin chk("instr_rdata", instr_rdata, rd); chk("instr_err", instr_err, me); end
         else if (m_own != 1) chk("instr_rdata0", instr_rdata, 0);
         if (erv && m_own == 2) begin chk("data_rdata", data_rdata, rd); chk("data_err", data_err, me); end
         else if (m_own != 2) chk("data_rdata0", data_rdata, 0);
         if (erv) begin
            m_own = 0; m_gr = 0;
         end else if (m_ig || m_dg) begin
            m_own = ro; m_gr = 1;
            m_st = (m_dg && ireq) ? (m_st + 1 > LIMIT ? LIMIT : m_st + 1) : 0;
         end else if (ro != 0) m_own = ro;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input bit ir, input logic [31:0] ia, input bit dr, input logic [31:0] da,
                      input bit dw, input logic [3:0] db, input logic [31:0] dd,
                      input bit gg, input bit rvv, input logic [31:0] rdd);
      tick();
      rst_n = 1; ireq = ir; iaddr = ia; dreq = dr; daddr = da; dwe = dw; dbe = db; dwd = dd;
      g = gg; rv = rvv; rd = rdd; me = 0;
   endtask

   initial begin
      repeat (3) tick();
      ireq = 1; iaddr = 32'h100; g = 1;
      #2 chk("lit_rst_req", mem_req, 0);
      chk("lit_rst_gnt", instr_gnt, 0);
      chk("lit_rst_state", 32'(dut.state_q), 32'(IDLE));
      drv(1, 'h100, 0, 0, 0, 0, 0, 1, 0, 0);
      #2 chk("lit_i_gnt", instr_gnt, 1); chk("lit_i_we", mem_we, 0);
      chk("lit_i_be", mem_be, 'hF); chk("lit_i_addr", mem_addr, 'h100);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h00500093);
      #2 chk("lit_i_rvalid", instr_rvalid, 1); chk("lit_i_rdata", instr_rdata, 'h00500093);
      drv(0, 0, 1, 'h2000, 1, 'h3, 'hDEADBEEF, 1, 0, 0);
      #2 chk("lit_st_addr", mem_addr, 'h2000); chk("lit_st_be", mem_be, 'h3);
      chk("lit_st_wdata", mem_wdata, 'hDEADBEEF); chk("lit_st_we", mem_we, 1); chk("lit_st_gnt", data_gnt, 1);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h1234);
      #2 chk("lit_st_rvalid", data_rvalid, 1); chk("lit_st_irvalid", instr_rvalid, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h5555);
      #2 chk("lit_stray_d", data_rvalid, 0); chk("lit_stray_i", instr_rvalid, 0);
      drv(1, 'h300, 1, 'h400, 0, 'hF, 0, 1, 0, 0);
      #2 chk("lit_sim_dgnt", data_gnt, 1); chk("lit_sim_ignt", instr_gnt, 0);
      drv(1, 'h300, 0, 0, 0, 0, 0, 1, 1, 'hAA);
      #2 chk("lit_sim_drv", data_rvalid, 1); chk("lit_sim_ignt_rv", instr_gnt, 0);
      drv(1, 'h300, 0, 0, 0, 0, 0, 1, 0, 0);
      #2 chk("lit_sim_ignt2", instr_gnt, 1); chk("lit_sim_iaddr", mem_addr, 'h300);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 'hBB);
      #2 chk("lit_sim_irv", instr_rvalid, 1);
      for (int k = 0; k < 5; k++) begin
         drv(1, 'h500, 1, 'h600 + k, 0, 'hF, k, 1, 0, 0);
         #2 chk("lit_starve_gnt", k < 4 ? data_gnt : instr_gnt, 1);
         drv(1, 'h500, 1, 'h600 + k, 0, 'hF, k, 0, 1, 'hC0 + k);
      end
      #2 chk("lit_starve_dut", dut.starve_q, 0); chk("lit_starve_model", m_st, 0);
      drv(0, 0, 1, 'h604, 0, 'hF, 4, 1, 0, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h1);
      drv(1, 'h700, 0, 0, 0, 0, 0, 0, 0, 0);
      #2 chk("lit_dly_req", mem_req, 1); chk("lit_dly_ignt", instr_gnt, 0);
      drv(1, 'h700, 1, 'h800, 0, 'hF, 0, 0, 0, 0);
      #2 chk("lit_dly_addr", mem_addr, 'h700); chk("lit_dly_dgnt", data_gnt, 0);
      drv(1, 'h700, 1, 'h800, 0, 'hF, 0, 0, 0, 0);
      drv(1, 'h700, 1, 'h800, 0, 'hF, 0, 1, 0, 0);
      #2 chk("lit_dly_ignt2", instr_gnt, 1); chk("lit_dly_dgnt2", data_gnt, 0); chk("lit_dly_addr2", mem_addr, 'h700);
      drv(0, 0, 1, 'h800, 0, 'hF, 0, 1, 1, 'hCC);
      #2 chk("lit_dly_irv", instr_rvalid, 1); chk("lit_dly_dgnt3", data_gnt, 0);
      drv(0, 0, 1, 'h800, 0, 'hF, 0, 1, 0, 0);
      #2 chk("lit_dly_dgnt4", data_gnt, 1); chk("lit_dly_addr3", mem_addr, 'h800);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h2);
      drv(1, 'h900, 0, 0, 0, 0, 0, 1, 0, 0);
      #2 chk("lit_rm_gnt", instr_gnt, 1);
      tick();
      rst_n = 0; ireq = 0; g = 0; rv = 1; rd = 'hDD;
      #2 chk("lit_rm_rv_in", instr_rvalid, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 'hDD);
      #2 chk("lit_rm_irv", instr_rvalid, 0); chk("lit_rm_drv", data_rvalid, 0);
      chk("lit_rm_state", 32'(dut.state_q), 32'(IDLE));
      repeat (3000) begin
         tick();
         if (!ireq || m_ig) begin ireq = $urandom_range(0, 2) != 0; iaddr = $urandom; end
         if (!dreq || m_dg) begin
            dreq = $urandom_range(0, 2) != 0; daddr = $urandom; dwe = $urandom_range(0, 1);
            dbe = 4'($urandom); dwd = $urandom;
         end
         g = $urandom_range(0, 2) != 0;
         rv = m_gr ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 9) == 0);
         rd = $urandom; me = $urandom_range(0, 1);
         rst_n = $urandom_range(0, 63) != 0;
      end
      @(negedge clk);
      model_step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single req/gnt/rvalid RAM port between the instruction-fetch interface and the load/store (data) interface of the CPU. One transaction is outstanding at a time. Data accesses win by default, with a starvation counter that forces an instruction grant after a bounded run of data grants. Sits between the CPU-side memory interfaces and the RAM model/macro.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; byte enables are `DATA_W/8`.
- `STARVE_LIMIT`, 4: number of consecutive data grants, while an instruction request waits, after which the instruction side gets priority (must be ≥1).

Ports:
- `clk_i` input 1: clock, rising edge.
- `rst_ni` input 1: reset; synchronous, active-low.
- `instr_req_i` input 1: fetch request.
- `instr_addr_i` input ADDR_W: fetch address.
- `instr_gnt_o` output 1: fetch accepted.
- `instr_rvalid_o` output 1: fetch data valid.
- `instr_rdata_o` output DATA_W: fetch data.
- `instr_err_o` output 1: fetch error.
- `data_req_i` input 1: load/store request.
- `data_addr_i` input ADDR_W: load/store address.
- `data_we_i` input 1: 1 = store.
- `data_be_i` input DATA_W/8: byte enables.
- `data_wdata_i` input DATA_W: store data.
- `data_gnt_o`, `data_rvalid_o` output 1 each: handshake toward the data side.
- `data_rdata_o` output DATA_W, `data_err_o` output 1: response toward the data side.
- `mem_req_o` output 1: request to the RAM.
- `mem_addr_o` output ADDR_W: RAM address.
- `mem_we_o` output 1: RAM write enable.
- `mem_be_o` output DATA_W/8: RAM byte enables.
- `mem_wdata_o` output DATA_W: RAM write data.
- `mem_gnt_i`, `mem_rvalid_i` input 1 each: RAM handshake.
- `mem_rdata_i` input DATA_W, `mem_err_i` input 1: RAM response.

## Operation
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID. Owner register: NONE/INSTR/DATA.
- **IDLE**
  - If any request is present, pick a winner combinationally.
    - Normal case: DATA wins if `data_req_i`; otherwise INSTR.
    - If `starve_cnt == STARVE_LIMIT` and `instr_req_i`: INSTR wins.
  - Drive `mem_req_o`=1 with the winner's addr/we/be/wdata.
  - Instruction transactions drive `mem_we_o`=0, `mem_be_o`=all-ones, `mem_wdata_o`=0.
  - If `mem_gnt_i` is high the same cycle: assert the winner's gnt, latch owner, go to WAIT_RVALID.
  - Otherwise latch owner and go to WAIT_GNT.
- **WAIT_GNT**
  - Request locked to owner: the other side's request is ignored, even a higher-priority data request.
  - `mem_req_o`=1 with the owner's signals; the requester holds them stable until gnt.
  - On `mem_gnt_i`: owner gnt=1, go to WAIT_RVALID.
- **WAIT_RVALID**
  - `mem_req_o`=0.
  - On `mem_rvalid_i`: route `mem_rdata_i`/`mem_err_i` to the owner with its rvalid=1 for one cycle, owner←NONE, go to IDLE.
  - Stores also receive an rvalid.
- Non-owner rvalid/gnt stay 0. Non-owner rdata is 0 (no X propagation).
- `mem_rvalid_i` in IDLE or WAIT_GNT is dropped and routed nowhere.
- Starvation counter, updated on each mem grant:
  - DATA granted while `instr_req_i`=1: `starve_cnt`++, saturating at STARVE_LIMIT.
  - INSTR granted, or DATA granted with no instruction pending: `starve_cnt`←0.
- Counter width: `$clog2(STARVE_LIMIT+1)`.
- Reset mid-transaction abandons it. No rvalid is forwarded afterwards, because owner is NONE.

## Timing
- Reset: state IDLE, owner NONE, `starve_cnt`=0.
- Registered outputs are 0 at reset. All gnt/rvalid outputs and `mem_req_o` are 0 while `rst_ni`=0.
- Grant path is combinational: `mem_gnt_i` → `*_gnt_o` in the same cycle.
- Response path is combinational: `mem_rvalid_i` → owner's `*_rvalid_o` and rdata in the same cycle.
- Minimum transaction: request+gnt in cycle N, rvalid in N+1, next request in N+2.
  - One idle bubble between back-to-back transactions is required.
  - Throughput is ≤ 1 access per 2 cycles.
- Simultaneous requests in IDLE resolve by the priority rule above; the loser keeps `req` asserted and is served next.
- `mem_gnt_i` is ignored in WAIT_RVALID.

## Structure
- Shared package `mem_arb_pkg` holds:
  - `arb_state_e` {IDLE, WAIT_GNT, WAIT_RVALID}
  - `arb_owner_e` {OWN_NONE, OWN_INSTR, OWN_DATA}
  - localparam `BE_ALL` for instruction byte enables.
- Single module; the starvation counter and muxes are small enough to stay inline, so no sub-module.

## Test plan
- **Instr only.** `instr_req_i`=1, addr 0x100, RAM grants immediately and rvalids next cycle with 0x00500093.
  - Expect: `instr_gnt_o`=1 in N, `instr_rvalid_o`=1 with rdata 0x00500093 in N+1, `mem_we_o`=0, `mem_be_o`=0xF.
- **Data store.** addr 0x2000, be 0x3, wdata 0xDEADBEEF.
  - Expect: mem_* signals mirror these exactly, `data_rvalid_o` pulses once, `instr_rvalid_o` stays 0.
- **Simultaneous requests.** Both request in the same IDLE cycle.
  - Expect: DATA granted first, INSTR granted in the next IDLE (N+2).
- **Starvation.** STARVE_LIMIT=4, data requests continuously, instr pending.
  - Expect: 4 data grants, then the 5th grant goes to INSTR, then `starve_cnt`=0.
- **Delayed gnt.** RAM holds gnt low 3 cycles.
  - Expect: `mem_req_o` stays 1 with the owner's address; a `data_req_i` raised during INSTR ownership is not granted until the next IDLE.
- **Reset mid-transaction.** Assert `rst_ni`=0 in WAIT_RVALID, then RAM rvalid after reset release.
  - Expect: no `*_rvalid_o`, state IDLE.
- **Stray rvalid.** RAM rvalid while in IDLE.
  - Expect: no `*_rvalid_o`.
